// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared constants for the pipeline control path.
//   * BYPASS_*  : forward-select values (0 = register file, k = stage k)
//   * pcsel_e   : next-PC source select used by the fetch unit
//   * hz_state_e: hazard controller FSM states
//   * sb_entry_t: one in-flight scoreboard entry, plus the bubble constant
package hazard_ctrl_pkg;

    // Forward select 0 always means "take the register-file read value".
    localparam int BYPASS_REGFILE = 0;

    typedef enum logic [1:0] {
        PCSEL_SEQ    = 2'd0,
        PCSEL_BRANCH = 2'd1,
        PCSEL_JUMP   = 2'd2,
        PCSEL_TRAP   = 2'd3
    } pcsel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    // Kill counter only needs to hold up to 3 squash slots.
    localparam int KILL_CW = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Build an entry for a live instruction; a write to x0 is recorded as
    // a non-write so that x0 can never forward or cause a stall.
    function automatic sb_entry_t make_entry(input logic [4:0] rd,
                                             input logic       we,
                                             input logic       load);
        sb_entry_t e;
        e.valid = 1'b1;
        e.rd    = rd;
        e.we    = we && (rd != 5'd0);
        e.load  = load;
        return e;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- decode-side handshake between the pipeline and the
// hazard controller.
//   pipeline -> controller: id_valid, id_rs1, id_rs2, id_rd, id_we, id_load,
//                           redirect
//   controller -> pipeline: stall, kill, fwd_a, fwd_b (SELW bits each),
//                           wb_we, wb_rd
// The pipeline uses the master modport, the controller the slave modport.
interface hazard_ctrl_if #(
    parameter int SELW = 2
);
    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_we;
    logic            id_load;
    logic            redirect;
    logic            stall;
    logic            kill;
    logic [SELW-1:0] fwd_a;
    logic [SELW-1:0] fwd_b;
    logic            wb_we;
    logic [4:0]      wb_rd;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, redirect,
        input  stall, kill, fwd_a, fwd_b, wb_we, wb_rd
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, redirect,
        output stall, kill, fwd_a, fwd_b, wb_we, wb_rd
    );
endinterface

// File: rtl/hazard_ctrl_sb_stage.sv
// hazard_sb_stage -- one scoreboard entry register with asynchronous reset.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears the entry to a bubble
//   d     : entry to capture on the next edge
//   q     : currently held entry
module hazard_sb_stage
    import hazard_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  sb_entry_t d,
    output sb_entry_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SB_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- decode-stage hazard unit: operand forwarding selects,
// load-use stall and post-redirect squash.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   hz    : hazard_ctrl_if.slave (decode inputs, redirect, stall/kill,
//           forward selects, writeback enable/address)
// Stage 1 of the scoreboard is X, stage NUM_STAGES is writeback.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int KILL_SLOTS = 1,
    parameter int SELW       = $clog2(NUM_STAGES + 1)
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    sb_entry_t sb_q [NUM_STAGES:1];
    sb_entry_t sb_d [NUM_STAGES:1];
    sb_entry_t entry_in;

    hz_state_e          state_q, state_d;
    logic [KILL_CW-1:0] kill_cnt_q, kill_cnt_d;
    logic [KILL_CW-1:0] kill_cnt_eff;

    logic            load_use;
    logic            stall;
    logic            kill;
    logic [SELW-1:0] fwd_a_sel;
    logic [SELW-1:0] fwd_b_sel;

    // ------------------------------------------------------------------
    // Forwarding: scan from the oldest stage down so the youngest
    // (lowest-numbered) matching producer wins.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_a_sel = SELW'(BYPASS_REGFILE);
        fwd_b_sel = SELW'(BYPASS_REGFILE);
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (sb_q[k].valid && sb_q[k].we && (sb_q[k].rd == hz.id_rs1)) begin
                fwd_a_sel = SELW'(k);
            end
            if (sb_q[k].valid && sb_q[k].we && (sb_q[k].rd == hz.id_rs2)) begin
                fwd_b_sel = SELW'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Load-use: load data is not forwardable until it has moved past
    // stage LOAD_LAT, so only stages 1..LOAD_LAT are checked.
    // ------------------------------------------------------------------
    always_comb begin
        load_use = 1'b0;
        for (int k = 1; k <= LOAD_LAT; k++) begin
            if (sb_q[k].valid && sb_q[k].we && sb_q[k].load &&
                ((sb_q[k].rd == hz.id_rs1) || (sb_q[k].rd == hz.id_rs2))) begin
                load_use = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller. The redirect cycle itself is the first kill slot: the
    // counter is loaded with KILL_SLOTS and consumes one slot in that same
    // cycle, so FLUSH covers the remaining KILL_SLOTS-1 slots. FLUSH is
    // therefore held exactly while the registered counter is nonzero.
    // ------------------------------------------------------------------
    always_comb begin
        kill  = hz.redirect || (state_q == ST_FLUSH);
        // A squashed instruction never needs to wait for its operands.
        stall = load_use && hz.id_valid && !kill;

        kill_cnt_eff = hz.redirect ? KILL_CW'(KILL_SLOTS) : kill_cnt_q;
        kill_cnt_d   = (kill_cnt_eff != '0) ? kill_cnt_eff - 1'b1 : '0;

        if (kill_cnt_d != '0) begin
            state_d = ST_FLUSH;
        end else if (stall) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            kill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard shift chain. Stage 1 takes the decode instruction or a
    // bubble when it is stalled, killed or absent.
    // ------------------------------------------------------------------
    always_comb begin
        entry_in = SB_BUBBLE;
        if (hz.id_valid && !stall && !kill) begin
            entry_in = make_entry(hz.id_rd, hz.id_we, hz.id_load);
        end
        sb_d[1] = entry_in;
        for (int k = 2; k <= NUM_STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    generate
        for (genvar gi = 1; gi <= NUM_STAGES; gi++) begin : g_stage
            hazard_sb_stage u_stage (
                .clk   (clk),
                .reset (reset),
                .d     (sb_d[gi]),
                .q     (sb_q[gi])
            );
        end
    endgenerate

    assign hz.stall = stall;
    assign hz.kill  = kill;
    assign hz.fwd_a = fwd_a_sel;
    assign hz.fwd_b = fwd_b_sel;
    assign hz.wb_we = sb_q[NUM_STAGES].valid && sb_q[NUM_STAGES].we;
    assign hz.wb_rd = sb_q[NUM_STAGES].rd;

endmodule
